// File: rtl/jtdsp16_pkg.sv
// Shared definitions for the DSP16 program fetch stage and its do-loop cache.
package jtdsp16_pkg;

   // Number of instructions a do-loop may hold; the do length field is 4 bits.
   localparam int CACHE_DEPTH = 15;

   // Fetch stage state encoding.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;
   localparam logic [1:0] ST_LOOP = 2'd2;

   // Field positions inside the do instruction operand.
   localparam int DO_N_MSB   = 10;
   localparam int DO_N_LSB   = 7;
   localparam int DO_CNT_MSB = 6;
   localparam int DO_CNT_LSB = 0;

   // Index into the loop cache.
   typedef logic [3:0] cache_idx_t;

endpackage

// File: rtl/jtdsp16_loop_cache.sv
// Storage for the do-loop instruction cache: DEPTH words plus a valid bit each.
module jtdsp16_loop_cache #(
   parameter int DEPTH = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear_all,
   input  logic        we,
   input  logic [3:0]  wr_idx,
   input  logic [15:0] wr_data,
   input  logic [3:0]  rd_idx,
   input  logic [3:0]  len,
   output logic [15:0] rd_data,
   output logic        rd_valid,
   output logic        all_valid
);

   logic [15:0]      mem_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] valid_d;
   logic             wr_ok;
   logic             rd_ok;

   assign wr_ok = int'(wr_idx) < DEPTH;
   assign rd_ok = int'(rd_idx) < DEPTH;

   // Clearing and writing in the same cycle leaves only the written entry valid.
   always_comb begin
      valid_d = valid_q;
      if (clear_all) begin
         valid_d = '0;
      end
      if (we && wr_ok) begin
         valid_d[wr_idx] = 1'b1;
      end
   end

   // Valid bits are the only cache state that reset has to invalidate.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Word storage; contents are meaningless until the matching valid bit is set.
   always_ff @(posedge clk) begin
      if (we && wr_ok) begin
         mem_q[wr_idx] <= wr_data;
      end
   end

   // Read port plus the "whole loop body captured" flag for the current length.
   always_comb begin
      rd_data   = '0;
      rd_valid  = 1'b0;
      all_valid = 1'b1;
      if (rd_ok) begin
         rd_data  = mem_q[rd_idx];
         rd_valid = valid_q[rd_idx];
      end
      for (int i = 0; i < DEPTH; i++) begin
         if ((i < int'(len)) && !valid_q[i]) begin
            all_valid = 1'b0;
         end
      end
   end

endmodule

// File: rtl/jtdsp16_prog_fetch.sv
// DSP16 program fetch stage: ROM handshake, instruction register and do-loop cache control.
module jtdsp16_prog_fetch #(
   parameter int CACHE_DEPTH = jtdsp16_pkg::CACHE_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cen,
   input  logic [15:0] rom_addr,
   input  logic        do_start,
   input  logic [10:0] do_data,
   input  logic        do_flush,
   output logic [15:0] ext_addr,
   output logic        ext_cs,
   input  logic [15:0] ext_data,
   input  logic        ext_ok,
   output logic [15:0] ins,
   output logic        ins_valid,
   output logic [15:0] rom_dout,
   output logic        fetch_wait,
   output logic        cache_hit
);
   import jtdsp16_pkg::*;

   logic [1:0]  state_q, state_d;
   logic [15:0] base_q, base_d;
   logic [3:0]  len_q, len_d;
   logic [15:0] ins_q, ins_d;
   logic        ins_valid_q, ins_valid_d;
   logic        cache_hit_q, cache_hit_d;

   logic [15:0] off;
   logic        in_range;
   logic        hit;
   logic [3:0]  do_len;
   logic        do_new;
   logic        do_redo;

   logic        c_we;
   logic        c_clear;
   cache_idx_t  c_widx;
   logic [15:0] c_rd_data;
   logic        c_rd_valid;
   logic        c_all_valid;

   logic        unused_do_count;

   assign unused_do_count = ^do_data[DO_CNT_MSB:DO_CNT_LSB];

   // Loop range check against the registered loop window, wrapping past 0xFFFF.
   always_comb begin
      do_len   = do_data[DO_N_MSB:DO_N_LSB];
      do_new   = do_start && (do_len != 4'd0);
      do_redo  = do_start && (do_len == 4'd0);
      off      = rom_addr - base_q;
      in_range = off < {12'd0, len_q};
      hit      = in_range && c_rd_valid && (state_q != ST_IDLE);
   end

   assign ext_addr   = rom_addr;
   assign ext_cs     = !hit && !rst;
   assign fetch_wait = ext_cs && !ext_ok;
   assign rom_dout   = hit ? c_rd_data : ext_data;

   // Cache write control. The word fetched alongside a new do instruction is the first
   // loop word, so it lands in entry 0 while the rest of the cache is cleared.
   always_comb begin
      c_clear = cen && do_new;
      c_widx  = do_new ? 4'd0 : off[3:0];
      c_we    = cen && ((do_new && (hit || ext_ok)) ||
                        (!hit && ext_ok && in_range && ((state_q == ST_FILL) || do_redo)));
   end

   jtdsp16_loop_cache #(
      .DEPTH     (CACHE_DEPTH)
   ) u_cache (
      .clk       (clk),
      .rst       (rst),
      .clear_all (c_clear),
      .we        (c_we),
      .wr_idx    (c_widx),
      .wr_data   (rom_dout),
      .rd_idx    (off[3:0]),
      .len       (len_q),
      .rd_data   (c_rd_data),
      .rd_valid  (c_rd_valid),
      .all_valid (c_all_valid)
   );

   // Loop FSM: a new do wins over a flush in the same cycle; a redo skips straight to
   // LOOP when the body is still fully cached from the previous run.
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      len_d   = len_q;
      if (cen) begin
         if (do_new) begin
            base_d  = rom_addr;
            len_d   = do_len;
            state_d = ST_FILL;
         end else if (do_redo) begin
            state_d = c_all_valid ? ST_LOOP : ST_FILL;
         end else if (do_flush) begin
            state_d = ST_IDLE;
         end else if ((state_q == ST_FILL) && c_all_valid) begin
            state_d = ST_LOOP;
         end
      end
   end

   // Instruction register: cache hits never wait, ROM words load only when ext_ok.
   always_comb begin
      ins_d       = ins_q;
      ins_valid_d = ins_valid_q;
      cache_hit_d = cache_hit_q;
      if (cen) begin
         if (hit) begin
            ins_d       = c_rd_data;
            ins_valid_d = 1'b1;
            cache_hit_d = 1'b1;
         end else if (ext_ok) begin
            ins_d       = ext_data;
            ins_valid_d = 1'b1;
            cache_hit_d = 1'b0;
         end else begin
            ins_valid_d = 1'b0;
            cache_hit_d = 1'b0;
         end
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         base_q      <= '0;
         len_q       <= '0;
         ins_q       <= '0;
         ins_valid_q <= 1'b0;
         cache_hit_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         len_q       <= len_d;
         ins_q       <= ins_d;
         ins_valid_q <= ins_valid_d;
         cache_hit_q <= cache_hit_d;
      end
   end

   assign ins       = ins_q;
   assign ins_valid = ins_valid_q;
   assign cache_hit = cache_hit_q;

endmodule
